// File: rtl/jelly_rtos_task_ctl.sv
// jelly_rtos_task_ctl: holds one task's state, nest counters, priority, wait
// cause, timeout and wait result, and requests ready-queue add/remove.
module jelly_rtos_task_ctl #(
    parameter int TSKID_WIDTH  = 4,
    parameter int TSKPRI_WIDTH = 4,
    parameter int FLGPTN_WIDTH = 4,
    parameter int RELTIM_WIDTH = 16,
    parameter int WUPCNT_WIDTH = 2,
    parameter int SUSCNT_WIDTH = 2,
    parameter int TSKID        = 0,
    parameter int INIT_TSKPRI  = TSKID,
    parameter bit INIT_ACT     = 1'b1
) (
    input  logic                    i_reset_n,
    input  logic                    i_clk,
    input  logic                    i_cke,
    input  logic                    i_tick,
    input  logic [TSKID_WIDTH-1:0]  i_run_tskid,
    input  logic                    i_op_valid,
    input  logic [3:0]              i_op_code,
    input  logic [TSKID_WIDTH-1:0]  i_op_tskid,
    input  logic [RELTIM_WIDTH-1:0] i_op_tmout,
    input  logic [TSKPRI_WIDTH-1:0] i_op_tskpri,
    input  logic                    i_op_wfmode,
    input  logic [FLGPTN_WIDTH-1:0] i_op_flgptn,
    input  logic                    i_rel_tsk,
    input  logic [FLGPTN_WIDTH-1:0] i_flgptn,
    input  logic                    i_rdy_tsk,
    output logic [TSKPRI_WIDTH-1:0] o_tskpri,
    output logic [4:0]              o_tskstat,
    output logic [3:0]              o_tskwait,
    output logic [WUPCNT_WIDTH-1:0] o_wupcnt,
    output logic [SUSCNT_WIDTH-1:0] o_suscnt,
    output logic [1:0]              o_ercd,
    output logic                    o_rdq_add,
    output logic                    o_rdq_rmv,
    output logic                    o_busy
);

    localparam logic [TSKID_WIDTH-1:0]  LP_TSKID    = TSKID[TSKID_WIDTH-1:0];
    localparam logic [TSKPRI_WIDTH-1:0] LP_INIT_PRI = INIT_TSKPRI[TSKPRI_WIDTH-1:0];
    localparam logic [RELTIM_WIDTH-1:0] TMO_FEVR    = {RELTIM_WIDTH{1'b1}};
    localparam logic [RELTIM_WIDTH-1:0] TIM_ONE     = {{(RELTIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WUPCNT_WIDTH-1:0] WUP_ONE     = {{(WUPCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SUSCNT_WIDTH-1:0] SUS_ONE     = {{(SUSCNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ACT     = 4'd0;
    localparam logic [3:0] OP_EXT     = 4'd1;
    localparam logic [3:0] OP_WUP     = 4'd2;
    localparam logic [3:0] OP_SLP     = 4'd3;
    localparam logic [3:0] OP_SUS     = 4'd4;
    localparam logic [3:0] OP_RSM     = 4'd5;
    localparam logic [3:0] OP_DLY     = 4'd6;
    localparam logic [3:0] OP_REL_WAI = 4'd7;
    localparam logic [3:0] OP_WAI_SEM = 4'd8;
    localparam logic [3:0] OP_WAI_FLG = 4'd9;
    localparam logic [3:0] OP_CHG_PRI = 4'd10;

    localparam logic [1:0] ERCD_OK    = 2'd0;
    localparam logic [1:0] ERCD_TMOUT = 2'd1;
    localparam logic [1:0] ERCD_RLWAI = 2'd2;

    // wait-cause bit positions, matching the {flg,sem,slp,dly} output order
    localparam int C_DLY = 0;
    localparam int C_SLP = 1;
    localparam int C_SEM = 2;
    localparam int C_FLG = 3;

    function automatic logic flg_match(input logic [FLGPTN_WIDTH-1:0] cur,
                                       input logic [FLGPTN_WIDTH-1:0] pat,
                                       input logic                    mode);
        return mode ? ((cur & pat) != '0) : ((cur & pat) == pat);
    endfunction

    logic                    r_dmt, r_sus, r_wai, r_rdq_add, r_wfmode;
    logic [3:0]              r_cause;
    logic [WUPCNT_WIDTH-1:0] r_wupcnt;
    logic [SUSCNT_WIDTH-1:0] r_suscnt;
    logic [1:0]              r_ercd;
    logic [TSKPRI_WIDTH-1:0] r_tskpri;
    logic [RELTIM_WIDTH-1:0] r_timcnt;
    logic [FLGPTN_WIDTH-1:0] r_flgptn;

    logic                    w_nxt_dmt, w_nxt_sus, w_nxt_wai, w_nxt_wfmode;
    logic [3:0]              w_nxt_cause;
    logic [WUPCNT_WIDTH-1:0] w_nxt_wupcnt;
    logic [SUSCNT_WIDTH-1:0] w_nxt_suscnt;
    logic [1:0]              w_nxt_ercd;
    logic [TSKPRI_WIDTH-1:0] w_nxt_tskpri;
    logic [RELTIM_WIDTH-1:0] w_nxt_timcnt;
    logic [FLGPTN_WIDTH-1:0] w_nxt_flgptn;
    logic                    w_add_set, w_rmv, w_rls, w_enter;
    logic [1:0]              w_rls_ercd;
    logic [3:0]              w_ent_cause;

    logic w_op_hit, w_run, w_rdy;
    assign w_op_hit = i_op_valid && (i_op_tskid == LP_TSKID);
    assign w_run    = (i_run_tskid == LP_TSKID) && !r_dmt;
    assign w_rdy    = !w_run && !r_wai && !r_sus && !r_dmt;

    // next state: timer, then wait release, then the service call on the post-release state
    always_comb begin
        w_nxt_dmt    = r_dmt;
        w_nxt_sus    = r_sus;
        w_nxt_wai    = r_wai;
        w_nxt_cause  = r_cause;
        w_nxt_wupcnt = r_wupcnt;
        w_nxt_suscnt = r_suscnt;
        w_nxt_ercd   = r_ercd;
        w_nxt_tskpri = r_tskpri;
        w_nxt_timcnt = r_timcnt;
        w_nxt_wfmode = r_wfmode;
        w_nxt_flgptn = r_flgptn;
        w_add_set    = 1'b0;
        w_rmv        = 1'b0;
        w_rls        = 1'b0;
        w_rls_ercd   = ERCD_OK;
        w_enter      = 1'b0;
        w_ent_cause  = '0;

        if (i_tick && (r_timcnt != '0)) begin
            w_nxt_timcnt = r_timcnt - TIM_ONE;
        end

        if (r_wai) begin
            if (w_op_hit && (i_op_code == OP_REL_WAI)) begin
                w_rls      = 1'b1;
                w_rls_ercd = ERCD_RLWAI;
            end else if (r_cause[C_SEM] && i_rel_tsk) begin
                w_rls = 1'b1;
            end else if (r_cause[C_FLG] && flg_match(i_flgptn, r_flgptn, r_wfmode)) begin
                w_rls = 1'b1;
            end else if (i_tick && (r_timcnt == TIM_ONE)) begin
                w_rls      = 1'b1;
                w_rls_ercd = r_cause[C_DLY] ? ERCD_OK : ERCD_TMOUT;
            end
        end

        if (w_rls) begin
            w_nxt_wai    = 1'b0;
            w_nxt_cause  = '0;
            w_nxt_timcnt = '0;
            w_nxt_ercd   = w_rls_ercd;
            w_add_set    = !r_sus;
        end

        if (w_op_hit) begin
            case (i_op_code)
                OP_ACT: if (r_dmt) begin
                    w_nxt_dmt    = 1'b0;
                    w_nxt_tskpri = LP_INIT_PRI;
                    w_nxt_wupcnt = '0;
                    w_nxt_suscnt = '0;
                    w_nxt_ercd   = ERCD_OK;
                    w_add_set    = 1'b1;
                end
                OP_EXT: if (!r_dmt) begin
                    w_nxt_dmt    = 1'b1;
                    w_nxt_wai    = 1'b0;
                    w_nxt_sus    = 1'b0;
                    w_nxt_cause  = '0;
                    w_nxt_wupcnt = '0;
                    w_nxt_suscnt = '0;
                    w_nxt_timcnt = '0;
                    w_rmv        = 1'b1;
                end
                OP_WUP: if (!r_dmt) begin
                    if (w_nxt_cause[C_SLP]) begin
                        w_nxt_wai    = 1'b0;
                        w_nxt_cause  = '0;
                        w_nxt_timcnt = '0;
                        w_nxt_ercd   = ERCD_OK;
                        w_add_set    = !w_nxt_sus;
                    end else if (w_nxt_wupcnt != '1) begin
                        w_nxt_wupcnt = w_nxt_wupcnt + WUP_ONE;
                    end
                end
                OP_SLP: if (w_run) begin
                    if (w_nxt_wupcnt != '0) begin
                        w_nxt_wupcnt = w_nxt_wupcnt - WUP_ONE;
                        w_nxt_ercd   = ERCD_OK;
                    end else begin
                        w_enter            = 1'b1;
                        w_ent_cause[C_SLP] = 1'b1;
                    end
                end
                OP_SUS: if (!r_dmt) begin
                    w_nxt_sus = 1'b1;
                    if (r_suscnt != '1) w_nxt_suscnt = r_suscnt + SUS_ONE;
                end
                OP_RSM: if (!r_dmt && (r_suscnt != '0)) begin
                    w_nxt_suscnt = r_suscnt - SUS_ONE;
                    if (r_suscnt == SUS_ONE) begin
                        w_nxt_sus = 1'b0;
                        if (!w_nxt_wai) w_add_set = 1'b1;
                    end
                end
                OP_DLY: if (w_run) begin
                    w_enter            = 1'b1;
                    w_ent_cause[C_DLY] = 1'b1;
                end
                OP_WAI_SEM: if (w_run) begin
                    w_enter            = 1'b1;
                    w_ent_cause[C_SEM] = 1'b1;
                end
                OP_WAI_FLG: if (w_run) begin
                    w_nxt_wfmode = i_op_wfmode;
                    w_nxt_flgptn = i_op_flgptn;
                    if (flg_match(i_flgptn, i_op_flgptn, i_op_wfmode)) begin
                        w_nxt_ercd = ERCD_OK;
                    end else begin
                        w_enter            = 1'b1;
                        w_ent_cause[C_FLG] = 1'b1;
                    end
                end
                OP_CHG_PRI: if (!r_dmt) begin
                    w_nxt_tskpri = i_op_tskpri;
                    if (w_rdy) begin
                        w_rmv     = 1'b1;
                        w_add_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // a zero timeout is a poll: report the outcome without ever leaving the queue
        if (w_enter) begin
            if (i_op_tmout == '0) begin
                w_nxt_ercd = w_ent_cause[C_DLY] ? ERCD_OK : ERCD_TMOUT;
            end else begin
                w_nxt_wai    = 1'b1;
                w_nxt_cause  = w_ent_cause;
                w_nxt_timcnt = (i_op_tmout == TMO_FEVR) ? '0 : i_op_tmout;
                w_rmv        = 1'b1;
            end
        end
    end

    // state registers; rdq_add holds until the ready queue samples it, with set winning
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dmt     <= ~INIT_ACT;
            r_sus     <= 1'b0;
            r_wai     <= 1'b0;
            r_cause   <= '0;
            r_wupcnt  <= '0;
            r_suscnt  <= '0;
            r_ercd    <= ERCD_OK;
            r_tskpri  <= LP_INIT_PRI;
            r_timcnt  <= '0;
            r_wfmode  <= 1'b0;
            r_flgptn  <= '0;
            r_rdq_add <= INIT_ACT;
        end else if (i_cke) begin
            r_dmt     <= w_nxt_dmt;
            r_sus     <= w_nxt_sus;
            r_wai     <= w_nxt_wai;
            r_cause   <= w_nxt_cause;
            r_wupcnt  <= w_nxt_wupcnt;
            r_suscnt  <= w_nxt_suscnt;
            r_ercd    <= w_nxt_ercd;
            r_tskpri  <= w_nxt_tskpri;
            r_timcnt  <= w_nxt_timcnt;
            r_wfmode  <= w_nxt_wfmode;
            r_flgptn  <= w_nxt_flgptn;
            r_rdq_add <= w_add_set | (r_rdq_add & ~i_rdy_tsk);
        end
    end

    assign o_tskpri  = r_tskpri;
    assign o_tskstat = {r_dmt, r_sus, r_wai, w_rdy, w_run};
    assign o_tskwait = r_cause;
    assign o_wupcnt  = r_wupcnt;
    assign o_suscnt  = r_suscnt;
    assign o_ercd    = r_ercd;
    assign o_rdq_add = r_rdq_add;
    assign o_rdq_rmv = i_cke & w_rmv;
    assign o_busy    = r_rdq_add;

endmodule

// File: tb/tb_jelly_rtos_task_ctl.sv
// tb_jelly_rtos_task_ctl: table-driven directed bench for jelly_rtos_task_ctl.
module tb_jelly_rtos_task_ctl;

    localparam int T   = 5;
    localparam int OTH = 1;
    localparam logic [3:0] T4   = 4'd5;
    localparam logic [3:0] OTH4 = 4'd1;

    localparam int ACT = 0, EXT = 1, WUP = 2, SLP = 3, SUS = 4, RSM = 5, DLY = 6;
    localparam int RELW = 7, WSEM = 8, WFLG = 9, CHGP = 10;
    localparam int FEVR = 'hFFFF;

    logic        clk = 1'b0;
    logic        reset_n, cke, tick, op_valid, op_wfmode, rel_tsk, rdy_tsk;
    logic [3:0]  run_tskid, op_code, op_tskid, op_tskpri, op_flgptn, flgptn;
    logic [15:0] op_tmout;
    logic [3:0]  tskpri, tskwait;
    logic [4:0]  tskstat;
    logic [1:0]  wupcnt, suscnt, ercd;
    logic        rdq_add, rdq_rmv, busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        opv;
        logic [3:0]  op;
        logic [3:0]  tid;
        logic [15:0] tmo;
        logic [3:0]  pri;
        logic        wfm;
        logic [3:0]  pat;
        logic        run;
        logic        rel;
        logic [3:0]  flg;
        logic        rdy;
        logic        tick;
        logic        e_rmv;
        logic [4:0]  e_stat;
        logic [3:0]  e_wait;
        logic [1:0]  e_wup;
        logic [1:0]  e_sus;
        logic [1:0]  e_ercd;
        logic        e_add;
        logic [3:0]  e_pri;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    jelly_rtos_task_ctl #(.TSKID(T)) dut (
        .i_reset_n   (reset_n),
        .i_clk       (clk),
        .i_cke       (cke),
        .i_tick      (tick),
        .i_run_tskid (run_tskid),
        .i_op_valid  (op_valid),
        .i_op_code   (op_code),
        .i_op_tskid  (op_tskid),
        .i_op_tmout  (op_tmout),
        .i_op_tskpri (op_tskpri),
        .i_op_wfmode (op_wfmode),
        .i_op_flgptn (op_flgptn),
        .i_rel_tsk   (rel_tsk),
        .i_flgptn    (flgptn),
        .i_rdy_tsk   (rdy_tsk),
        .o_tskpri    (tskpri),
        .o_tskstat   (tskstat),
        .o_tskwait   (tskwait),
        .o_wupcnt    (wupcnt),
        .o_suscnt    (suscnt),
        .o_ercd      (ercd),
        .o_rdq_add   (rdq_add),
        .o_rdq_rmv   (rdq_rmv),
        .o_busy      (busy)
    );

    function automatic vec_t mkv(input int opv, op, tid, tmo, pri, wfm, pat,
                                 input int run, rel, flg, rdy, tk,
                                 input int rmv, stat, wt, wup, sus, er, add, epri);
        vec_t v;
        v.opv = opv[0];     v.op = op[3:0];     v.tid = tid[3:0];   v.tmo = tmo[15:0];
        v.pri = pri[3:0];   v.wfm = wfm[0];     v.pat = pat[3:0];   v.run = run[0];
        v.rel = rel[0];     v.flg = flg[3:0];   v.rdy = rdy[0];     v.tick = tk[0];
        v.e_rmv = rmv[0];   v.e_stat = stat[4:0]; v.e_wait = wt[3:0]; v.e_wup = wup[1:0];
        v.e_sus = sus[1:0]; v.e_ercd = er[1:0]; v.e_add = add[0];   v.e_pri = epri[3:0];
        return v;
    endfunction

    function automatic void addv(input int opv, op, tid, tmo, pri, wfm, pat,
                                 input int run, rel, flg, rdy, tk,
                                 input int rmv, stat, wt, wup, sus, er, add, epri);
        vecs.push_back(mkv(opv, op, tid, tmo, pri, wfm, pat, run, rel, flg, rdy, tk,
                           rmv, stat, wt, wup, sus, er, add, epri));
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        op_valid  = 1'b0;
        run_tskid = OTH4;
        tick      = 1'b0;
        rel_tsk   = 1'b0;
        rdy_tsk   = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        op_valid  = v.opv;
        op_code   = v.op;
        op_tskid  = v.tid;
        op_tmout  = v.tmo;
        op_tskpri = v.pri;
        op_wfmode = v.wfm;
        op_flgptn = v.pat;
        run_tskid = v.run ? T4 : OTH4;
        rel_tsk   = v.rel;
        flgptn    = v.flg;
        rdy_tsk   = v.rdy;
        tick      = v.tick;
    endtask

    task automatic check_outs(input vec_t v, input int idx);
        chk($sformatf("v%0d tskstat", idx), 16'(tskstat), 16'(v.e_stat));
        chk($sformatf("v%0d tskwait", idx), 16'(tskwait), 16'(v.e_wait));
        chk($sformatf("v%0d wupcnt", idx),  16'(wupcnt),  16'(v.e_wup));
        chk($sformatf("v%0d suscnt", idx),  16'(suscnt),  16'(v.e_sus));
        chk($sformatf("v%0d ercd", idx),    16'(ercd),    16'(v.e_ercd));
        chk($sformatf("v%0d rdq_add", idx), 16'(rdq_add), 16'(v.e_add));
        chk($sformatf("v%0d busy", idx),    16'(busy),    16'(v.e_add));
        chk($sformatf("v%0d tskpri", idx),  16'(tskpri),  16'(v.e_pri));
    endtask

    // entered at posedge+2: drive, check the combinational remove, clock, check state
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #3;
        chk($sformatf("v%0d rdq_rmv", idx), 16'(rdq_rmv), 16'(v.e_rmv));
        @(posedge clk);
        #1;
        idle();
        #1;
        check_outs(v, idx);
    endtask

    initial begin
        reset_n   = 1'b0;
        cke       = 1'b1;
        op_code   = '0;
        op_tskid  = '0;
        op_tmout  = '0;
        op_tskpri = '0;
        op_wfmode = 1'b0;
        op_flgptn = '0;
        flgptn    = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdq_rmv", 16'(rdq_rmv), 16'd0);
        check_outs(mkv(0,0,0,0,0,0,0, 0,0,0,0,0, 0,'h02,0,0,0,0,1,5), 99);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        //   opv op    tid tmo   pri wfm pat  run rel flg rdy tk   rmv stat  wt  wup sus er add pri
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  0, 0,  5);
        addv(1, SLP,  T,  3,    0,  0,  0,   1,  0,  0,  0,  0,   1,  'h04, 2,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  0,  1,   0,  'h04, 2,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  0,  1,   0,  'h04, 2,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  0,  1,   0,  'h02, 0,  0,  0,  1, 1,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  1, 0,  5);
        addv(1, WUP,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  1,  0,  1, 0,  5);
        addv(1, WUP,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  2,  0,  1, 0,  5);
        addv(1, WUP,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  3,  0,  1, 0,  5);
        addv(1, WUP,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  3,  0,  1, 0,  5);
        addv(1, SLP,  T,  3,    0,  0,  0,   1,  0,  0,  0,  0,   0,  'h02, 0,  2,  0,  0, 0,  5);
        addv(1, SLP,  T,  3,    0,  0,  0,   1,  0,  0,  0,  0,   0,  'h02, 0,  1,  0,  0, 0,  5);
        addv(1, SLP,  T,  3,    0,  0,  0,   1,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  0, 0,  5);
        addv(1, SLP,  T,  FEVR, 0,  0,  0,   1,  0,  0,  0,  0,   1,  'h04, 2,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  0,  1,   0,  'h04, 2,  0,  0,  0, 0,  5);
        addv(1, WUP,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  0, 1,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  0, 0,  5);
        addv(1, WFLG, T,  FEVR, 0,  1,  5,   1,  0,  0,  0,  0,   1,  'h04, 8,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  4,  0,  0,   0,  'h02, 0,  0,  0,  0, 1,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  0, 0,  5);
        addv(1, WFLG, T,  2,    0,  0,  5,   1,  0,  4,  0,  0,   1,  'h04, 8,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  4,  0,  0,   0,  'h04, 8,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  4,  0,  1,   0,  'h04, 8,  0,  0,  0, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  4,  0,  1,   0,  'h02, 0,  0,  0,  1, 1,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  1, 0,  5);
        addv(1, WFLG, T,  2,    0,  0,  5,   1,  0,  7,  0,  0,   0,  'h02, 0,  0,  0,  0, 0,  5);
        addv(1, WSEM, T,  0,    0,  0,  0,   1,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  1, 0,  5);
        addv(1, WSEM, T,  10,   0,  0,  0,   1,  0,  0,  0,  0,   1,  'h04, 4,  0,  0,  1, 0,  5);
        addv(1, SUS,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h0C, 4,  0,  1,  1, 0,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  1,  0,  0,  0,   0,  'h08, 0,  0,  1,  0, 0,  5);
        addv(1, RSM,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  0, 1,  5);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  0, 0,  5);
        addv(1, CHGP, T,  0,    9,  0,  0,   0,  0,  0,  0,  0,   1,  'h02, 0,  0,  0,  0, 1,  9);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  0, 0,  9);
        addv(1, WUP,  2,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  0, 0,  9);
        addv(1, WSEM, T,  0,    0,  0,  0,   1,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  1, 0,  9);
        addv(1, DLY,  T,  2,    0,  0,  0,   1,  0,  0,  0,  0,   1,  'h04, 1,  0,  0,  1, 0,  9);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  0,  1,   0,  'h04, 1,  0,  0,  1, 0,  9);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  0,  1,   0,  'h02, 0,  0,  0,  0, 1,  9);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  0, 0,  9);
        addv(1, WSEM, T,  1,    0,  0,  0,   1,  0,  0,  0,  0,   1,  'h04, 4,  0,  0,  0, 0,  9);
        addv(1, RELW, T,  0,    0,  0,  0,   0,  1,  0,  0,  1,   0,  'h02, 0,  0,  0,  2, 1,  9);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  2, 0,  9);
        addv(1, SUS,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h08, 0,  0,  1,  2, 0,  9);
        addv(1, CHGP, T,  0,    3,  0,  0,   0,  0,  0,  0,  0,   0,  'h08, 0,  0,  1,  2, 0,  3);
        addv(1, SUS,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h08, 0,  0,  2,  2, 0,  3);
        addv(1, RSM,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h08, 0,  0,  1,  2, 0,  3);
        addv(1, RSM,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  2, 1,  3);
        addv(0, 0,    0,  0,    0,  0,  0,   0,  0,  0,  1,  0,   0,  'h02, 0,  0,  0,  2, 0,  3);
        addv(1, EXT,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   1,  'h10, 0,  0,  0,  2, 0,  3);
        addv(1, WUP,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h10, 0,  0,  0,  2, 0,  3);
        addv(1, ACT,  T,  0,    0,  0,  0,   0,  0,  0,  0,  0,   0,  'h02, 0,  0,  0,  0, 1,  5);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // clock enable low: an op and a ready-queue handshake must both be held off
        cke = 1'b0;
        apply(mkv(1, WUP, T, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 'h02, 0, 0, 0, 0, 1, 5), 100);
        cke = 1'b1;

        // reset asserted while waiting with a changed priority and a TMOUT result
        apply(mkv(0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 'h02, 0, 0, 0, 0, 0, 5), 101);
        apply(mkv(1, WSEM, T, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 'h02, 0, 0, 0, 1, 0, 5), 102);
        apply(mkv(1, WSEM, T, 5, 0, 0, 0, 1, 0, 0, 0, 0,  1, 'h04, 4, 0, 0, 1, 0, 5), 103);
        apply(mkv(1, CHGP, T, 0, 7, 0, 0, 0, 0, 0, 0, 0,  0, 'h04, 4, 0, 0, 1, 0, 7), 104);
        apply(mkv(0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 'h04, 4, 0, 0, 1, 0, 7), 105);
        reset_n = 1'b0;
        #1;
        check_outs(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 'h02, 0, 0, 0, 0, 1, 5), 106);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 'h02, 0, 0, 0, 0, 1, 5), 107 + i);
        end
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 'h02, 0, 0, 0, 0, 0, 5), 112);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
